// File: rtl/uart_pkg.sv
// Shared constants and types for the UART soft IP interrupt path.
package uart_pkg;

    localparam int UFIFO_USED_WIDTH = 5;
    localparam int DFIFO_USED_WIDTH = 5;

    localparam int IRQ_EVENTS_NUM = 8;

    localparam int IRQ_UFIFO_THR   = 0;
    localparam int IRQ_DFIFO_THR   = 1;
    localparam int IRQ_UFIFO_FULL  = 2;
    localparam int IRQ_DFIFO_EMPTY = 3;
    localparam int IRQ_RX_TIMEOUT  = 4;
    localparam int IRQ_UFIFO_OVF   = 5;
    localparam int IRQ_PARITY_ERR  = 6;
    localparam int IRQ_FRAME_ERR   = 7;

    typedef logic [IRQ_EVENTS_NUM-1:0] uart_irq_vec_t;

endpackage

// File: rtl/uart_irq_timeout.sv
// RX idle-timeout: counts clocks since the last FIFO strobe while the upstream
// FIFO holds data, and emits one registered event pulse per idle period.
module uart_irq_timeout #(
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                     i_apb_pclk,
    input  logic                     i_apb_presetn,
    input  logic                     i_ufifo_empty,
    input  logic                     i_ufifo_wr_req,
    input  logic                     i_ufifo_rd_req,
    input  logic [TIMEOUT_WIDTH-1:0] i_rx_timeout,
    output logic                     o_timeout_event
);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_COUNT = 2'b01;
    localparam logic [1:0] ST_FIRED = 2'b10;

    logic [1:0]               state;
    logic [TIMEOUT_WIDTH-1:0] cnt;
    logic                     strobe;
    logic                     disarm;
    logic                     terminal;

    assign strobe   = i_ufifo_wr_req | i_ufifo_rd_req;
    assign disarm   = i_ufifo_empty | (i_rx_timeout == '0);
    // Compare one bit wider so cnt+1 cannot wrap at all-ones.
    assign terminal = ({1'b0, cnt} + 1'b1) == {1'b0, i_rx_timeout};

    always_ff @(posedge i_apb_pclk or negedge i_apb_presetn) begin
        if (!i_apb_presetn) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            o_timeout_event <= 1'b0;
        end else begin
            o_timeout_event <= 1'b0;
            if (disarm) begin
                state <= ST_IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_COUNT;
                        cnt   <= '0;
                    end
                    ST_COUNT: begin
                        if (strobe) begin
                            cnt <= '0;
                        end else if (terminal) begin
                            o_timeout_event <= 1'b1;
                            state           <= ST_FIRED;
                        end else if (cnt != '1) begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_FIRED: begin
                        if (strobe) begin
                            state <= ST_COUNT;
                            cnt   <= '0;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/uart_irq_ctrl.sv
// UART interrupt controller: turns FIFO/RX status into sticky pending bits
// and one registered, masked level interrupt.
module uart_irq_ctrl
    import uart_pkg::*;
#(
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                        i_apb_pclk,
    input  logic                        i_apb_presetn,
    input  uart_irq_vec_t               i_irq_mask,
    input  uart_irq_vec_t               i_irq_clear,
    input  logic [UFIFO_USED_WIDTH:0]   i_ufifo_used,
    input  logic                        i_ufifo_full,
    input  logic                        i_ufifo_empty,
    input  logic                        i_ufifo_wr_req,
    input  logic                        i_ufifo_rd_req,
    input  logic [DFIFO_USED_WIDTH:0]   i_dfifo_used,
    input  logic                        i_dfifo_empty,
    input  logic [UFIFO_USED_WIDTH:0]   i_ufifo_thresh,
    input  logic [DFIFO_USED_WIDTH:0]   i_dfifo_thresh,
    input  logic                        i_rx_parity_err,
    input  logic                        i_rx_frame_err,
    input  logic [TIMEOUT_WIDTH-1:0]    i_rx_timeout,
    output uart_irq_vec_t               o_irq_pending,
    output logic                        o_irq
);

    // Level conditions whose rising edges are events 0..3.
    logic [3:0]    lvl;
    logic [3:0]    lvl_q;
    logic          timeout_event;
    uart_irq_vec_t events;

    always_comb begin
        lvl                  = '0;
        lvl[IRQ_UFIFO_THR]   = i_ufifo_used >= i_ufifo_thresh;
        lvl[IRQ_DFIFO_THR]   = i_dfifo_used <= i_dfifo_thresh;
        lvl[IRQ_UFIFO_FULL]  = i_ufifo_full;
        lvl[IRQ_DFIFO_EMPTY] = i_dfifo_empty;
    end

    always_comb begin
        events                 = '0;
        events[3:0]            = lvl & ~lvl_q;
        events[IRQ_RX_TIMEOUT] = timeout_event;
        events[IRQ_UFIFO_OVF]  = i_ufifo_wr_req & i_ufifo_full;
        events[IRQ_PARITY_ERR] = i_rx_parity_err;
        events[IRQ_FRAME_ERR]  = i_rx_frame_err;
    end

    // Previous-value reset of 1 on the downstream bits keeps an empty
    // downstream FIFO from raising events on reset exit.
    always_ff @(posedge i_apb_pclk or negedge i_apb_presetn) begin
        if (!i_apb_presetn) begin
            lvl_q         <= 4'b1010;
            o_irq_pending <= '0;
            o_irq         <= 1'b0;
        end else begin
            lvl_q         <= lvl;
            o_irq_pending <= (o_irq_pending & ~i_irq_clear) | events;
            o_irq         <= |(o_irq_pending & i_irq_mask);
        end
    end

    uart_irq_timeout #(
        .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
    ) u_timeout (
        .i_apb_pclk      (i_apb_pclk),
        .i_apb_presetn   (i_apb_presetn),
        .i_ufifo_empty   (i_ufifo_empty),
        .i_ufifo_wr_req  (i_ufifo_wr_req),
        .i_ufifo_rd_req  (i_ufifo_rd_req),
        .i_rx_timeout    (i_rx_timeout),
        .o_timeout_event (timeout_event)
    );

endmodule

// File: tb/tb_uart_irq_ctrl.sv
// Bench for uart_irq_ctrl: directed scenarios plus randomized traffic, checked
// cycle by cycle against a time-based reference model through an expected queue.
module tb_uart_irq_ctrl;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [7:0]  mask = '0, clear = '0;
    logic [5:0]  uused = '0, uthr = 6'd4, dused = '0, dthr = '0;
    logic        ufull = 0, uempty = 1, wr = 0, rd = 0, dempty = 1, perr = 0, ferr = 0;
    logic [15:0] tmo = '0;
    wire  [7:0]  pend;
    wire         irq;

    uart_irq_ctrl #(.TIMEOUT_WIDTH(16)) dut (
        .i_apb_pclk      (clk),
        .i_apb_presetn   (rst_n),
        .i_irq_mask      (mask),
        .i_irq_clear     (clear),
        .i_ufifo_used    (uused),
        .i_ufifo_full    (ufull),
        .i_ufifo_empty   (uempty),
        .i_ufifo_wr_req  (wr),
        .i_ufifo_rd_req  (rd),
        .i_dfifo_used    (dused),
        .i_dfifo_empty   (dempty),
        .i_ufifo_thresh  (uthr),
        .i_dfifo_thresh  (dthr),
        .i_rx_parity_err (perr),
        .i_rx_frame_err  (ferr),
        .i_rx_timeout    (tmo),
        .o_irq_pending   (pend),
        .o_irq           (irq)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    // Timeout is modelled in absolute edge numbers: the event is due when
    // exactly N edges have passed since the last restart of the idle period.
    logic [8:0] exp_q[$];
    logic [7:0] m_pend;
    logic       m_irq;
    logic       m_uthr_was, m_dthr_was, m_full_was, m_dempty_was;
    logic       m_active, m_fired, m_tmo_due;
    int         edge_n = 0;
    int         restart_edge = 0;

    always @(posedge clk) begin
        logic [7:0] ev;
        logic uthr_now, dthr_now;
        if (!rst_n) begin
            m_pend = '0; m_irq = 1'b0;
            m_uthr_was = 1'b0; m_dthr_was = 1'b1; m_full_was = 1'b0; m_dempty_was = 1'b1;
            m_active = 1'b0; m_fired = 1'b0; m_tmo_due = 1'b0;
        end else begin
            uthr_now = (uused >= uthr);
            dthr_now = (dused <= dthr);
            ev = '0;
            ev[0] = uthr_now && !m_uthr_was;
            ev[1] = dthr_now && !m_dthr_was;
            ev[2] = ufull && !m_full_was;
            ev[3] = dempty && !m_dempty_was;
            ev[4] = m_tmo_due;
            ev[5] = wr && ufull;
            ev[6] = perr;
            ev[7] = ferr;
            m_tmo_due = 1'b0;
            if (uempty || tmo == 0) begin
                m_active = 1'b0;
            end else if (!m_active || wr || rd) begin
                m_active = 1'b1; m_fired = 1'b0; restart_edge = edge_n;
            end else if (!m_fired && (edge_n - restart_edge) == int'(tmo)) begin
                m_tmo_due = 1'b1; m_fired = 1'b1;
            end
            m_irq  = |(m_pend & mask);
            m_pend = (m_pend & ~clear) | ev;
            m_uthr_was = uthr_now; m_dthr_was = dthr_now;
            m_full_was = ufull;    m_dempty_was = dempty;
        end
        exp_q.push_back({m_irq, m_pend});
        edge_n++;
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [8:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({irq, pend} !== e) begin
                errors++;
                $display("FAIL scoreboard t=%0t: got irq=%b pend=%02h, expected irq=%b pend=%02h",
                         $time, irq, pend, e[8], e[7:0]);
            end
        end
    end

    int  tmo_sets = 0;
    logic p4_q = 1'b0;
    always @(negedge clk) begin
        if (pend[4] === 1'b1 && !p4_q) tmo_sets++;
        p4_q = (pend[4] === 1'b1);
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic pulse_clear(input logic [7:0] v);
        clear = v; step(); clear = '0;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base;
        rst_n = 1'b0;
        steps(10);
        check("reset_pend", pend, 0);
        check("reset_irq", irq, 0);
        rst_n = 1'b1;
        steps(10);
        check("post_reset_pend", pend, 0);

        // upstream threshold edge, 2-cycle irq latency, clear
        mask = 8'h01; uused = 6'd3; step();
        uused = 6'd4; step();
        check("uthr_pend", pend, 8'h01);
        check("uthr_irq_lat1", irq, 0);
        step();
        check("uthr_irq_lat2", irq, 1);
        pulse_clear(8'h01);
        check("clr_pend", pend, 8'h00);
        check("clr_irq_still", irq, 1);
        step();
        check("clr_irq_drop", irq, 0);

        // overflow with simultaneous clear: set wins
        ufull = 1'b1; wr = 1'b1; clear = 8'h20; step();
        wr = 1'b0; clear = '0;
        check("ovf_set_wins", pend[5], 1);
        pulse_clear(8'hFF);

        // timeout: event 11 cycles after the write, once, rearm on write
        base = tmo_sets;
        tmo = 16'd10; uempty = 1'b0; wr = 1'b1; step(); wr = 1'b0;
        steps(10);
        check("tmo_not_early", pend[4], 0);
        step();
        check("tmo_on_time", pend[4], 1);
        step();
        pulse_clear(8'h10);
        steps(90);
        check("tmo_once", tmo_sets - base, 1);
        wr = 1'b1; step(); wr = 1'b0;
        steps(11);
        check("tmo_rearm", pend[4], 1);
        pulse_clear(8'h10);

        // empty during count cancels the timeout
        wr = 1'b1; step(); wr = 1'b0;
        steps(5);
        uempty = 1'b1;
        steps(20);
        check("tmo_cancel", pend[4], 0);

        // error pulses masked, then unmasked
        tmo = '0; mask = '0;
        pulse_clear(8'hFF);
        perr = 1'b1; ferr = 1'b1; step(); perr = 1'b0; ferr = 1'b0;
        check("err_pend", pend, 8'hC0);
        step();
        check("err_irq_masked", irq, 0);
        mask = 8'h40; step();
        check("err_irq_unmask", irq, 1);

        // asynchronous reset in the middle of a count
        pulse_clear(8'hFF);
        tmo = 16'd10; uempty = 1'b0; wr = 1'b1; step(); wr = 1'b0;
        steps(4);
        rst_n = 1'b0; #1;
        check("async_reset_pend", pend, 0);
        check("async_reset_irq", irq, 0);
        steps(2);
        rst_n = 1'b1;
        steps(20);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            mask  = ($urandom_range(0, 15) == 0) ? 8'($urandom) : mask;
            clear = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
            uused = 6'($urandom_range(0, 32));
            dused = 6'($urandom_range(0, 32));
            if ($urandom_range(0, 30) == 0) uthr = 6'($urandom_range(0, 32));
            if ($urandom_range(0, 30) == 0) dthr = 6'($urandom_range(0, 32));
            if ($urandom_range(0, 10) == 0) ufull = ~ufull;
            if ($urandom_range(0, 10) == 0) dempty = ~dempty;
            if ($urandom_range(0, 40) == 0) uempty = ~uempty;
            if ($urandom_range(0, 150) == 0) tmo = 16'($urandom_range(0, 12));
            wr   = ($urandom_range(0, 19) == 0);
            rd   = ($urandom_range(0, 24) == 0);
            perr = ($urandom_range(0, 40) == 0);
            ferr = ($urandom_range(0, 40) == 0);
            step();
        end
        wr = 0; rd = 0; perr = 0; ferr = 0; clear = '0;
        steps(3);
        check("queue_drained", exp_q.size() <= 1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
